// File: rtl/spi_tx_fifo_pkg.sv
// Shared word/depth defaults for the SPI transmit path. spi_master and spi_tx_fifo take their
// widths from here so the word size stays consistent across both blocks.
package spi_tx_fifo_pkg;

  localparam int unsigned SPI_WORD_WIDTH = 8;
  localparam int unsigned SPI_FIFO_DEPTH = 16;

endpackage

// File: rtl/spi_tx_fifo_if.sv
// Valid/data/ready word stream.
//   valid  word present (driven by master)
//   data   word        (driven by master)
//   ready  sink accepts (driven by slave)
// A word transfers on a rising clock edge with valid & ready.
interface spi_tx_fifo_if
  import spi_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_WORD_WIDTH
);

  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/spi_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for spi_tx_fifo.
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
// Storage is deliberately not reset; occupancy is tracked by the pointers in the parent.
module spi_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// First-word fall-through word buffer feeding spi_master.
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   flush     synchronous clear of all entries and overflow
//   s_if      upstream stream (slave): ready = !full
//   m_if      downstream stream (master): valid = !empty, data = head word
//   full      occupancy == DEPTH
//   empty     occupancy == 0
//   overflow  sticky, set by a push attempt while full
//   level     occupancy, registered (only with SPI_TX_FIFO_LEVEL_EN)
// Optional feature macro: SPI_TX_FIFO_LEVEL_EN.
module spi_tx_fifo
  import spi_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_WORD_WIDTH,
  parameter int unsigned DEPTH       = SPI_FIFO_DEPTH,
  parameter int unsigned DEPTH_CLOG2 = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  spi_tx_fifo_if.slave         s_if,
  spi_tx_fifo_if.master        m_if,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
`ifdef SPI_TX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_CLOG2:0] level
`endif
);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [DEPTH_CLOG2:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_CLOG2:0]  rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_CLOG2] != rd_ptr_q[DEPTH_CLOG2]) &&
                 (wr_ptr_q[DEPTH_CLOG2-1:0] == rd_ptr_q[DEPTH_CLOG2-1:0]);

  // No full-bypass: a pop in the same cycle does not open a slot for the push.
  assign push = s_if.valid && !full;
  assign pop  = m_if.ready && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (s_if.valid & full);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Writes only ever land on a free slot, so the head entry is never overwritten.
  spi_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (DEPTH_CLOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q[DEPTH_CLOG2-1:0]),
    .wdata (s_if.data),
    .raddr (rd_ptr_q[DEPTH_CLOG2-1:0]),
    .rdata (head_data)
  );

  assign s_if.ready = !full;
  assign m_if.valid = !empty;
  // Mask the unreset storage so the head reads zero while nothing is queued.
  assign m_if.data  = empty ? '0 : head_data;
  assign overflow   = overflow_q;

`ifdef SPI_TX_FIFO_LEVEL_EN
  logic [DEPTH_CLOG2:0] level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= wr_ptr_d - rd_ptr_d;
    end
  end

  assign level = level_q;
`endif

endmodule
